// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings for the data-memory access unit
package mips_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int         UNS_BIT = 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane extraction/extension and store-lane merge
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] shifted;

    always_comb begin
        sh        = 5'd0;
        mask      = 32'hFFFF_FFFF;
        shifted   = 32'h0;
        load_data = word;
        case (size)
            SZ_BYTE: begin
                // offset 0 is the most significant byte
                sh        = {~offset, 3'b000};
                mask      = 32'h0000_00FF;
                shifted   = word >> sh;
                load_data = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sh        = {~offset[1], 4'b0000};
                mask      = 32'h0000_FFFF;
                shifted   = word >> sh;
                load_data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
        merged_word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the word-wide big-endian data memory
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_t      state;
    logic        we_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [2:0]  cnt;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    always_comb begin
        case (req_op[1:0])
            SZ_BYTE: acc_err = 1'b0;
            SZ_HALF: acc_err = req_addr[0];
            SZ_WORD: acc_err = |req_addr[1:0];
            default: acc_err = 1'b1;
        endcase
    end

    mem_lane_align u_align (
        .word        (mem_read_data),
        .offset      (off_q),
        .size        (op_q[1:0]),
        .uns         (op_q[UNS_BIT]),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            op_q           <= 3'b0;
            off_q          <= 2'b0;
            wdata_q        <= 32'h0;
            cnt            <= 3'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 32'h0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q        <= req_we;
                    op_q        <= req_op;
                    off_q       <= req_addr[1:0];
                    wdata_q     <= req_wdata;
                    mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                    cnt         <= CNT_INIT;
                    if (acc_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else if (req_we && req_op[1:0] == SZ_WORD) begin
                        state          <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= req_wdata;
                    end else begin
                        // sub-word stores read the word first and merge
                        state    <= READ;
                        mem_read <= 1'b1;
                    end
                end
                READ: begin
                    if (cnt == 3'd0) begin
                        mem_read <= 1'b0;
                        if (we_q) begin
                            state          <= WRITE;
                            mem_write      <= 1'b1;
                            mem_write_data <= merged_word;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= load_data;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench: latency 1 and latency 3 units against a byte-level model
module tb_mem_access_unit;
    logic        clk;
    logic        rst_n          [2];
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_we         [2];
    logic [2:0]  req_op         [2];
    logic [31:0] req_addr       [2];
    logic [31:0] req_wdata      [2];
    logic        resp_valid     [2];
    logic [31:0] resp_rdata     [2];
    logic        resp_err       [2];
    logic        mem_read       [2];
    logic        mem_write      [2];
    logic [31:0] mem_address    [2];
    logic [31:0] mem_write_data [2];
    logic [31:0] mem_read_data  [2];

    logic [7:0]  rmem [2][64];
    int          errors = 0;
    int          checks = 0;
    int          cycle_no = 0;
    int          last_wr [2];
    logic        mem_load;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            2:       return 32'h1122_3344;
            3:       return 32'h8012_34F0;
            4:       return 32'hCAFE_F00D;
            5:       return 32'h0000_0000;
            default: return 32'h0101_0101 * i;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_no <= cycle_no + 1;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        logic [31:0] dmem [16];
        assign mem_read_data[g] = dmem[mem_address[g][5:2]];
        always @(posedge clk) begin
            if (mem_load) begin
                for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
            end else if (mem_write[g]) begin
                dmem[mem_address[g][5:2]] <= mem_write_data[g];
            end
        end

        mem_access_unit #(.MEM_LATENCY(g == 0 ? 1 : 3), .ADDR_W(32)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .req_valid      (req_valid[g]),
            .req_ready      (req_ready[g]),
            .req_we         (req_we[g]),
            .req_op         (req_op[g]),
            .req_addr       (req_addr[g]),
            .req_wdata      (req_wdata[g]),
            .resp_valid     (resp_valid[g]),
            .resp_rdata     (resp_rdata[g]),
            .resp_err       (resp_err[g]),
            .mem_read       (mem_read[g]),
            .mem_write      (mem_write[g]),
            .mem_address    (mem_address[g]),
            .mem_write_data (mem_write_data[g]),
            .mem_read_data  (mem_read_data[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model works on bytes: big-endian assembly, arithmetic sign extension, per-byte store.
    task automatic do_req(input int k, input bit we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input bit lit_en, input logic [31:0] lit);
        int lat_l, n, exp_lat, exp_rc, exp_wc, cyc, rc, wc, bound;
        bit err, got;
        longint v;
        logic [31:0] exp_rd, exp_wd, wdat, waddr;
        logic [5:0] a;
        lat_l = (k == 0) ? 1 : 3;
        a = addr[5:0];
        case (op[1:0])
            2'b00: n = 1;
            2'b01: n = 2;
            2'b10: n = 4;
            default: n = 0;
        endcase
        err = (n == 0) || (int'(addr) % n != 0);
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (!err && !we) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v * 256 + longint'(rmem[k][a + 6'(i)]);
            if (!op[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            exp_rd = v[31:0];
        end
        if (!err && we) begin
            for (int i = 0; i < n; i++) rmem[k][a + 6'(i)] = wd[8 * (n - 1 - i) +: 8];
            for (int i = 0; i < 4; i++) exp_wd = {exp_wd[23:0], rmem[k][{a[5:2], 2'b00} + 6'(i)]};
        end
        exp_lat = err ? 1 : (we ? (n == 4 ? 2 : 2 + lat_l) : 1 + lat_l);
        exp_rc  = (!err && (!we || n < 4)) ? lat_l : 0;
        exp_wc  = (!err && we) ? 1 : 0;
        waddr   = {addr[31:2], 2'b00};

        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_op[k]    = op;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        bound = 0;
        while (!req_ready[k] && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("ready_before_accept", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        cyc = 0; rc = 0; wc = 0; got = 0; wdat = 32'h0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req_valid[k] = 1'b0;
            chk("ready_low_busy", 32'(req_ready[k]), 32'd0);
            if (mem_read[k]) begin
                rc++;
                chk("rd_addr", mem_address[k], waddr);
            end
            if (mem_write[k]) begin
                wc++;
                wdat = mem_write_data[k];
                chk("wr_addr", mem_address[k], waddr);
                if (last_wr[k] >= 0) chk("wr_gap_ge3", 32'(cycle_no - last_wr[k] >= 3), 32'd1);
                last_wr[k] = cycle_no;
            end
            if (resp_valid[k]) begin
                got = 1;
                chk("resp_mem_idle", {30'h0, mem_read[k], mem_write[k]}, 32'h0);
                chk("resp_addr_held", mem_address[k], (exp_rc + exp_wc > 0) ? waddr : mem_address[k] | 32'h0);
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("resp_rdata", resp_rdata[k], exp_rd);
        chk("resp_err", 32'(resp_err[k]), 32'(err));
        chk("read_cycles", 32'(rc), 32'(exp_rc));
        chk("write_cycles", 32'(wc), 32'(exp_wc));
        if (exp_wc == 1) chk("write_data", wdat, exp_wd);
        if (lit_en) chk("literal", we ? wdat : resp_rdata[k], lit);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_op[k] = 3'b0;
            req_addr[k] = 32'h0; req_wdata[k] = 32'h0; last_wr[k] = -1;
            for (int i = 0; i < 16; i++)
                for (int b = 0; b < 4; b++) rmem[k][i * 4 + b] = init_word(i)[31 - 8 * b -: 8];
        end
        mem_load = 1'b1;
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_strobes", {28'h0, mem_read[k], mem_write[k], resp_valid[k], resp_err[k]}, 32'h0);
            chk("rst_addr", mem_address[k], 32'h0);
            chk("rst_wdata", mem_write_data[k], 32'h0);
            chk("rst_rdata", resp_rdata[k], 32'h0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        do_req(0, 0, 3'b010, 32'h0C, 32'h0, 1, 32'h8012_34F0);
        do_req(0, 0, 3'b000, 32'h0C, 32'h0, 1, 32'hFFFF_FF80);
        do_req(0, 0, 3'b100, 32'h0F, 32'h0, 1, 32'h0000_00F0);
        do_req(0, 0, 3'b001, 32'h0E, 32'h0, 1, 32'h0000_34F0);
        do_req(0, 0, 3'b101, 32'h0C, 32'h0, 1, 32'h0000_8012);
        do_req(0, 1, 3'b000, 32'h0D, 32'h0000_00AB, 1, 32'h80AB_34F0);
        do_req(0, 0, 3'b010, 32'h0C, 32'h0, 1, 32'h80AB_34F0);
        do_req(0, 1, 3'b010, 32'h0E, 32'h1234_5678, 1, 32'h0);
        do_req(0, 0, 3'b001, 32'h0D, 32'h0, 1, 32'h0);
        do_req(0, 0, 3'b011, 32'h0C, 32'h0, 1, 32'h0);
        do_req(0, 1, 3'b101, 32'h0E, 32'h0000_1234, 1, 32'h80AB_1234);
        do_req(0, 0, 3'b001, 32'h0C, 32'h0, 1, 32'hFFFF_80AB);

        do_req(1, 0, 3'b010, 32'h10, 32'h0, 1, 32'hCAFE_F00D);
        do_req(1, 1, 3'b010, 32'h10, 32'h0102_0304, 1, 32'h0102_0304);
        do_req(1, 1, 3'b010, 32'h14, 32'h0506_0708, 1, 32'h0506_0708);
        do_req(1, 0, 3'b010, 32'h14, 32'h0, 1, 32'h0506_0708);
        do_req(1, 0, 3'b100, 32'h12, 32'h0, 1, 32'h0000_0003);

        // Reset during the WRITE cycle of a halfword store: no write, no response.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_op[1] = 3'b001;
        req_addr[1] = 32'h08; req_wdata[1] = 32'h0000_BEEF;
        begin
            int n_cyc;
            bit seen;
            n_cyc = 0; seen = 0;
            @(posedge clk);
            while (!seen && n_cyc < 12) begin
                @(negedge clk);
                n_cyc++;
                req_valid[1] = 1'b0;
                seen = mem_write[1];
            end
            chk("rst_test_write_seen", 32'(seen), 32'd1);
        end
        rst_n[1] = 1'b0;
        #1;
        chk("async_drop_write", 32'(mem_write[1]), 32'd0);
        chk("async_no_resp", 32'(resp_valid[1]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        rst_n[1] = 1'b1;
        last_wr[1] = -1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("post_rst_no_resp", 32'(resp_valid[1]), 32'd0);
        do_req(1, 0, 3'b010, 32'h08, 32'h0, 1, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
